// File: rtl/camera_pkg.sv
// -----------------------------------------------------------------------------
// camera_pkg
// Shared definitions for the pixel-domain capture path: the capture FSM state
// type, the RGB332 bit-slice positions taken from each 10-bit channel, and the
// 2x2 ordered-dither matrix used when CAPTURE_WRITER_DITHER_EN is defined.
// No ports (package).
// -----------------------------------------------------------------------------
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURING,
    DONE
  } capture_state_t;

  // RGB332 keeps the top 3 bits of red/green and the top 2 bits of blue
  localparam int RED_MSB   = 9;
  localparam int RED_LSB   = 7;
  localparam int GREEN_MSB = 9;
  localparam int GREEN_LSB = 7;
  localparam int BLUE_MSB  = 9;
  localparam int BLUE_LSB  = 8;

  // 2x2 ordered dither, indexed by {y0, x0}:
  // (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1
  localparam logic [7:0] DITHER_MATRIX = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] dither_offset(input logic y0, input logic x0);
    return DITHER_MATRIX[{y0, x0, 1'b0} +: 2];
  endfunction

  // Sum fits in 11 bits (1023 + 192), so bit 10 flags anything above 1023
  function automatic logic [9:0] saturating_add(input logic [9:0] value,
                                                input logic [10:0] offset);
    logic [10:0] sum;
    sum = {1'b0, value} + offset;
    return sum[10] ? 10'h3FF : sum[9:0];
  endfunction

endpackage

// File: rtl/capture_writer_if.sv
// -----------------------------------------------------------------------------
// capture_writer_if
// Pixel bus carried from the capture writer into the RGB332 packer: the three
// 10-bit colour channels plus the low bits of the pixel x/y position that
// select the dither matrix entry.
// Modports: master drives the bus, slave consumes it.
// -----------------------------------------------------------------------------
interface capture_writer_if;

  logic [9:0] red;
  logic [9:0] green;
  logic [9:0] blue;
  logic       x0;
  logic       y0;

  modport master (output red, green, blue, x0, y0);
  modport slave  (input  red, green, blue, x0, y0);

endinterface

// File: rtl/capture_writer_rgb332_packer.sv
// -----------------------------------------------------------------------------
// rgb332_packer
// Combinational reduction of a 10-bit-per-channel pixel to RGB332.
// Optional feature: CAPTURE_WRITER_DITHER_EN adds a 2x2 ordered dither
// (red/green +m*32, blue +m*64, saturating at 1023) before truncation.
// Ports:
//   pixel        capture_writer_if.slave  channels and x0/y0
//   packed_data  output [7:0]             {r[9:7], g[9:7], b[9:8]}
// -----------------------------------------------------------------------------
module rgb332_packer
  import camera_pkg::*;
(
  capture_writer_if.slave pixel,
  output logic [7:0]      packed_data
);

  logic [9:0] red_d;
  logic [9:0] green_d;
  logic [9:0] blue_d;

`ifdef CAPTURE_WRITER_DITHER_EN
  logic [1:0] dither_m;

  always_comb begin
    dither_m = dither_offset(pixel.y0, pixel.x0);
    red_d    = saturating_add(pixel.red,   {4'b0, dither_m, 5'b0});
    green_d  = saturating_add(pixel.green, {4'b0, dither_m, 5'b0});
    blue_d   = saturating_add(pixel.blue,  {3'b0, dither_m, 6'b0});
  end
`else
  logic unused_position;

  assign red_d           = pixel.red;
  assign green_d         = pixel.green;
  assign blue_d          = pixel.blue;
  assign unused_position = pixel.x0 ^ pixel.y0;
`endif

  // Truncated low bits are intentionally discarded
  logic unused_low_bits;
  assign unused_low_bits = ^{red_d[RED_LSB-1:0], green_d[GREEN_LSB-1:0],
                             blue_d[BLUE_LSB-1:0]};

  assign packed_data = {red_d[RED_MSB:RED_LSB],
                        green_d[GREEN_MSB:GREEN_LSB],
                        blue_d[BLUE_MSB:BLUE_LSB]};

endmodule

// File: rtl/capture_writer.sv
// -----------------------------------------------------------------------------
// capture_writer
// Pixel-domain stage between the crop stage and the image buffer. Runs the
// single-frame capture FSM (IDLE -> ARMED -> CAPTURING -> DONE), packs each
// captured pixel to RGB332 and writes it to the buffer one cycle after it
// arrives. Optional dither: define CAPTURE_WRITER_DITHER_EN.
// Ports:
//   clock_pixel_in, reset_pixel_in (sync, active-high)
//   capture_request_in                      single-cycle capture request
//   pixel_{red,green,blue}_data_in [9:0]    cropped pixel
//   line_valid_in, frame_valid_in           cropped timing
//   buffer_write_{address,data,enable}_out  registered buffer write port
//   capture_busy_out / capture_done_out     ARMED|CAPTURING / DONE
//   captured_pixel_count_out                pixels written this capture
//   overflow_out                            sticky, frame exceeded MAX_PIXELS
// -----------------------------------------------------------------------------
module capture_writer
  import camera_pkg::*;
#(
  parameter int MAX_PIXELS    = 40000,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clock_pixel_in,
  input  logic                     reset_pixel_in,
  input  logic                     capture_request_in,
  input  logic [9:0]               pixel_red_data_in,
  input  logic [9:0]               pixel_green_data_in,
  input  logic [9:0]               pixel_blue_data_in,
  input  logic                     line_valid_in,
  input  logic                     frame_valid_in,
  output logic [ADDRESS_WIDTH-1:0] buffer_write_address_out,
  output logic [7:0]               buffer_write_data_out,
  output logic                     buffer_write_enable_out,
  output logic                     capture_busy_out,
  output logic                     capture_done_out,
  output logic [ADDRESS_WIDTH-1:0] captured_pixel_count_out,
  output logic                     overflow_out
);

  localparam logic [ADDRESS_WIDTH-1:0] MAX_COUNT = ADDRESS_WIDTH'(MAX_PIXELS);
  localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);

  capture_state_t           state;
  logic                     frame_valid_q;
  logic                     line_valid_q;
  logic [ADDRESS_WIDTH-1:0] x_count;
  logic [ADDRESS_WIDTH-1:0] y_count;
  logic                     pixel_valid;
  logic                     frame_start;
  logic                     frame_end;
  logic                     line_end;
  logic                     capture_pixel;
  logic [7:0]               packed_pixel;

  assign pixel_valid = frame_valid_in & line_valid_in;
  assign frame_start = frame_valid_in & ~frame_valid_q;
  assign frame_end   = ~frame_valid_in & frame_valid_q;
  assign line_end    = ~line_valid_in & line_valid_q;

  // The frame_start cycle itself may already carry a pixel, so ARMED treats it
  // as the first capture cycle; otherwise that pixel would be silently lost.
  assign capture_pixel = pixel_valid &
                         ((state == CAPTURING) | ((state == ARMED) & frame_start));

  capture_writer_if pixel_bus ();

  assign pixel_bus.red   = pixel_red_data_in;
  assign pixel_bus.green = pixel_green_data_in;
  assign pixel_bus.blue  = pixel_blue_data_in;
  assign pixel_bus.x0    = x_count[0];
  assign pixel_bus.y0    = y_count[0];

  rgb332_packer u_packer (
    .pixel       (pixel_bus),
    .packed_data (packed_pixel)
  );

  // Capture FSM, position counters and the registered buffer write port.
  // Busy/done are updated alongside each state transition so they always
  // match the registered state.
  always_ff @(posedge clock_pixel_in) begin
    if (reset_pixel_in) begin
      state                    <= IDLE;
      frame_valid_q            <= 1'b0;
      line_valid_q             <= 1'b0;
      x_count                  <= '0;
      y_count                  <= '0;
      buffer_write_address_out <= '0;
      buffer_write_data_out    <= '0;
      buffer_write_enable_out  <= 1'b0;
      capture_busy_out         <= 1'b0;
      capture_done_out         <= 1'b0;
      captured_pixel_count_out <= '0;
      overflow_out             <= 1'b0;
    end else begin
      frame_valid_q           <= frame_valid_in;
      line_valid_q            <= line_valid_in;
      buffer_write_enable_out <= 1'b0;

      if (pixel_valid) begin
        x_count <= x_count + ONE;
      end else if (!line_valid_in) begin
        x_count <= '0;
      end

      if (frame_start) begin
        y_count <= '0;
      end else if (line_end) begin
        y_count <= y_count + ONE;
      end

      case (state)
        IDLE, DONE: begin
          if (capture_request_in) begin
            state                    <= ARMED;
            capture_busy_out         <= 1'b1;
            capture_done_out         <= 1'b0;
            captured_pixel_count_out <= '0;
            overflow_out             <= 1'b0;
          end
        end
        ARMED: begin
          if (frame_start) begin
            state <= CAPTURING;
          end
        end
        CAPTURING: begin
          if (frame_end) begin
            state            <= DONE;
            capture_busy_out <= 1'b0;
            capture_done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Pixels beyond buffer capacity are dropped and flagged, count holds
      if (capture_pixel) begin
        if (captured_pixel_count_out < MAX_COUNT) begin
          buffer_write_enable_out  <= 1'b1;
          buffer_write_address_out <= captured_pixel_count_out;
          buffer_write_data_out    <= packed_pixel;
          captured_pixel_count_out <= captured_pixel_count_out + ONE;
        end else begin
          overflow_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_writer.sv
// -----------------------------------------------------------------------------
// tb_capture_writer
// Self-checking bench for capture_writer. Frames are described by their line
// and pixel counts; the reference model decides per frame whether it is
// captured and lists the expected buffer writes, which are compared against
// the writes observed on the buffer port.
// -----------------------------------------------------------------------------
module tb_capture_writer;

  localparam int TB_MAX_PIXELS = 20;
  localparam int TB_AW         = 16;

  logic             clock_pixel;
  logic             reset_pixel;
  logic             capture_request;
  logic             line_valid;
  logic             frame_valid;
  logic [TB_AW-1:0] write_address;
  logic [7:0]       write_data;
  logic             write_enable;
  logic             capture_busy;
  logic             capture_done;
  logic [TB_AW-1:0] pixel_count;
  logic             overflow;

  capture_writer_if pix ();

  capture_writer #(
    .MAX_PIXELS    (TB_MAX_PIXELS),
    .ADDRESS_WIDTH (TB_AW)
  ) dut (
    .clock_pixel_in           (clock_pixel),
    .reset_pixel_in           (reset_pixel),
    .capture_request_in       (capture_request),
    .pixel_red_data_in        (pix.red),
    .pixel_green_data_in      (pix.green),
    .pixel_blue_data_in       (pix.blue),
    .line_valid_in            (line_valid),
    .frame_valid_in           (frame_valid),
    .buffer_write_address_out (write_address),
    .buffer_write_data_out    (write_data),
    .buffer_write_enable_out  (write_enable),
    .capture_busy_out         (capture_busy),
    .capture_done_out         (capture_done),
    .captured_pixel_count_out (pixel_count),
    .overflow_out             (overflow)
  );

  initial clock_pixel = 1'b0;
  always #5 clock_pixel = ~clock_pixel;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: whether a capture is pending/running, and its results
  bit modelBusy  = 0;
  bit modelDone  = 0;
  int modelCount = 0;
  bit modelOver  = 0;

  logic [15:0] obsAddr[$];
  logic [7:0]  obsData[$];
  logic [15:0] expAddr[$];
  logic [7:0]  expData[$];

  // Record every buffer write strobe seen on the port
  always @(negedge clock_pixel) begin
    if (write_enable === 1'b1) begin
      obsAddr.push_back(write_address);
      obsData.push_back(write_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] packRef(input int r, input int g, input int b,
                                         input int x, input int y);
    int rr;
    int gg;
    int bb;
    rr = r;
    gg = g;
    bb = b;
`ifdef CAPTURE_WRITER_DITHER_EN
    begin
      int m;
      if (y % 2 == 0) m = (x % 2 == 0) ? 0 : 2;
      else            m = (x % 2 == 0) ? 3 : 1;
      rr = (rr + m * 32 > 1023) ? 1023 : rr + m * 32;
      gg = (gg + m * 32 > 1023) ? 1023 : gg + m * 32;
      bb = (bb + m * 64 > 1023) ? 1023 : bb + m * 64;
    end
`endif
    return 8'((rr / 128) * 32 + (gg / 128) * 4 + (bb / 256));
  endfunction

  // Drive one cycle of inputs just after a falling edge; returns on the next
  // falling edge, when the registered outputs for that cycle are stable.
  task automatic applyStimulus(input logic req, input logic fv, input logic lv,
                               input logic [9:0] r, input logic [9:0] g,
                               input logic [9:0] b);
    capture_request = req;
    frame_valid     = fv;
    line_valid      = lv;
    pix.red         = r;
    pix.green       = g;
    pix.blue        = b;
    @(negedge clock_pixel);
  endtask

  function automatic void modelRequest();
    if (!modelBusy) begin
      modelBusy  = 1;
      modelDone  = 0;
      modelCount = 0;
      modelOver  = 0;
    end
  endfunction

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_busy"},  32'(capture_busy), 32'(modelBusy));
    checkOutput({tag, "_done"},  32'(capture_done), 32'(modelDone));
    checkOutput({tag, "_count"}, 32'(pixel_count),  32'(modelCount));
    checkOutput({tag, "_ovf"},   32'(overflow),     32'(modelOver));
  endtask

  task automatic sendRequest(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    modelRequest();
    checkStatus(tag);
  endtask

  // One frame of 'lines' lines x 'ppl' pixels, optionally with a request
  // pulse on frame cycle reqAt (-1 for none).
  task automatic sendFrame(input string tag, input int lines, input int ppl,
                           input bit fixedData, input logic [9:0] fr,
                           input logic [9:0] fg, input logic [9:0] fb,
                           input int reqAt);
    bit         capturing;
    int         n;
    int         c;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    int         shown;
    capturing = modelBusy;
    n = 0;
    c = 0;
    obsAddr.delete();
    obsData.delete();
    expAddr.delete();
    expData.delete();
    applyStimulus(c == reqAt, 1'b1, 1'b0, '0, '0, '0);
    if (c == reqAt) modelRequest();
    c++;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < ppl; x++) begin
        r = fixedData ? fr : 10'($urandom_range(0, 1023));
        g = fixedData ? fg : 10'($urandom_range(0, 1023));
        b = fixedData ? fb : 10'($urandom_range(0, 1023));
        applyStimulus(c == reqAt, 1'b1, 1'b1, r, g, b);
        if (c == reqAt) modelRequest();
        if (capturing) begin
          if (n < TB_MAX_PIXELS) begin
            expAddr.push_back(16'(n));
            expData.push_back(packRef(int'(r), int'(g), int'(b), x, y));
          end
          n++;
        end
        c++;
      end
      applyStimulus(c == reqAt, 1'b1, 1'b0, '0, '0, '0);
      if (c == reqAt) modelRequest();
      c++;
    end
    applyStimulus(c == reqAt, 1'b0, 1'b0, '0, '0, '0);
    if (c == reqAt) modelRequest();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    if (capturing) begin
      modelCount = (n < TB_MAX_PIXELS) ? n : TB_MAX_PIXELS;
      modelOver  = (n > TB_MAX_PIXELS);
      modelBusy  = 0;
      modelDone  = 1;
    end
    checkOutput({tag, "_writes"}, 32'(obsAddr.size()), 32'(expAddr.size()));
    shown = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
    for (int i = 0; i < shown; i++) begin
      checkOutput({tag, "_addr"}, 32'(obsAddr[i]), 32'(expAddr[i]));
      checkOutput({tag, "_data"}, 32'(obsData[i]), 32'(expData[i]));
    end
    checkStatus(tag);
  endtask

  initial begin
    int total;
    int reqAt;
    int lines;
    int ppl;
    reset_pixel = 1'b1;
    pix.x0 = 1'b0;
    pix.y0 = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("reset_we",   32'(write_enable),  32'h0);
    checkOutput("reset_addr", 32'(write_address), 32'h0);
    checkOutput("reset_data", 32'(write_data),    32'h0);
    checkStatus("reset");
    reset_pixel = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Basic 2x3 white frame
    sendRequest("basic_req");
    sendFrame("basic", 2, 3, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, -1);

    // Request mid-frame: current frame skipped, next one captured
    sendFrame("midreq", 2, 3, 1'b0, '0, '0, '0, 2);
    sendFrame("midnext", 1, 4, 1'b0, '0, '0, '0, -1);

    // Overflow past capacity, then a new request clears it
    sendRequest("ovf_req");
    sendFrame("ovf", 5, 5, 1'b0, '0, '0, '0, -1);
    sendRequest("ovf_clear");
    sendFrame("ovf_after", 1, 2, 1'b0, '0, '0, '0, -1);

    // Packing of fixed colours, and a dither position case
    sendRequest("pack_req");
    sendFrame("pack", 1, 1, 1'b1, 10'h380, 10'h080, 10'h300, -1);
    sendRequest("dith_req");
    sendFrame("dither", 1, 2, 1'b1, 10'h37F, 10'h000, 10'h000, -1);

    // Request during capture is ignored; following frame is not captured
    sendRequest("ign_req");
    sendFrame("ignored", 2, 4, 1'b0, '0, '0, '0, 3);
    sendFrame("no_rearm", 1, 3, 1'b0, '0, '0, '0, -1);

    // Reset after 2 of 5 pixels abandons the capture
    sendRequest("rst_req");
    obsAddr.delete();
    obsData.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    reset_pixel = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    modelBusy  = 0;
    modelDone  = 0;
    modelCount = 0;
    modelOver  = 0;
    checkOutput("rst_we",   32'(write_enable),  32'h0);
    checkOutput("rst_addr", 32'(write_address), 32'h0);
    checkOutput("rst_data", 32'(write_data),    32'h0);
    checkStatus("rst_mid");
    reset_pixel = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("rst_writes", 32'(obsAddr.size()), 32'd2);
    checkStatus("rst_after");

    // Randomized sequences of requests and frames
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) sendRequest("rnd_req");
      lines = $urandom_range(1, 5);
      ppl   = $urandom_range(1, 6);
      total = 2 + lines * (ppl + 1);
      reqAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      sendFrame("rnd", lines, ppl, 1'b0, '0, '0, '0, reqAt);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
